// File: rtl/result_packetizer_pkg.sv
// Shared framing constants and FSM encoding for the result packetizer.
// Byte indices follow the on-wire order of the 9-byte packet.
package result_packetizer_pkg;

    localparam logic [7:0] PKT_SYNC0 = 8'hA5;
    localparam logic [7:0] PKT_SYNC1 = 8'h5A;
    localparam int         PKT_LEN   = 9;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [3:0] IDX_SYNC0  = 4'd0;
    localparam logic [3:0] IDX_SYNC1  = 4'd1;
    localparam logic [3:0] IDX_SEQ    = 4'd2;
    localparam logic [3:0] IDX_HR_H   = 4'd3;
    localparam logic [3:0] IDX_HR_M   = 4'd4;
    localparam logic [3:0] IDX_HR_L   = 4'd5;
    localparam logic [3:0] IDX_SPO2_H = 4'd6;
    localparam logic [3:0] IDX_SPO2_L = 4'd7;
    localparam logic [3:0] IDX_CSUM   = 4'(PKT_LEN - 1);

endpackage

// File: rtl/result_packetizer_fifo.sv
// Small synchronous result FIFO with registered read port.
// Pointers carry an extra wrap bit to tell full from empty.
module result_packetizer_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            dout <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                dout <= mem[rptr[AW-1:0]];
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; a simultaneous push into a full slot reads old data first.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/result_packetizer.sv
// Buffers HR/SpO2 results and frames each one as a checksummed 9-byte packet.
// Results arriving into a full FIFO are dropped and counted instead of stalling.
module result_packetizer
    import result_packetizer_pkg::*;
#(
    parameter int         DEPTH  = 4,
    parameter int         HR_W   = 24,
    parameter int         SPO2_W = 10,
    parameter logic [7:0] SYNC0  = PKT_SYNC0,
    parameter logic [7:0] SYNC1  = PKT_SYNC1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [HR_W-1:0]   in_hr,
    input  logic [SPO2_W-1:0] in_spo2,
    input  logic              stream_en,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        drop_count
);

    localparam int W = HR_W + SPO2_W;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        idx;
    logic [7:0]        seq;
    logic [7:0]        csum;
    logic              fifo_full;
    logic              fifo_empty;
    logic              start;
    logic              push;
    logic              drop;
    logic              xfer;
    logic              last;
    logic [W-1:0]      hold;
    logic [HR_W-1:0]   hr_f;
    logic [SPO2_W-1:0] spo2_f;
    logic [23:0]       hr_x;
    logic [15:0]       spo2_x;

    // The FIFO's registered read port doubles as the packet holding register.
    result_packetizer_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (start),
        .din   ({in_hr, in_spo2}),
        .dout  (hold),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {hr_f, spo2_f} = hold;
    assign hr_x   = 24'(hr_f);
    assign spo2_x = 16'(spo2_f);

    assign start = (state == IDLE) && stream_en && !fifo_empty;
    assign push  = in_valid && (!fifo_full || start);
    assign drop  = in_valid && fifo_full && !start;
    assign xfer  = out_valid && out_ready;
    assign last  = (idx == IDX_CSUM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = SEND;
            SEND: if (xfer && last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == SEND);
        busy      = (state == SEND);
        out_byte  = 8'h00;
        if (state == SEND) begin
            unique case (idx)
                IDX_SYNC0:  out_byte = SYNC0;
                IDX_SYNC1:  out_byte = SYNC1;
                IDX_SEQ:    out_byte = seq;
                IDX_HR_H:   out_byte = hr_x[23:16];
                IDX_HR_M:   out_byte = hr_x[15:8];
                IDX_HR_L:   out_byte = hr_x[7:0];
                IDX_SPO2_H: out_byte = spo2_x[15:8];
                IDX_SPO2_L: out_byte = spo2_x[7:0];
                IDX_CSUM:   out_byte = csum;
                default:    out_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            seq        <= '0;
            csum       <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (start) begin
                idx  <= '0;
                csum <= '0;
            end else if (xfer) begin
                idx <= last ? 4'd0 : idx + 4'd1;
                if (idx >= IDX_SEQ && idx <= IDX_SPO2_L) begin
                    csum <= csum + out_byte;
                end
                if (last) begin
                    seq <= seq + 8'd1;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_result_packetizer.sv
// Directed testbench for result_packetizer: framing, handshake,
// overflow, sequence wrap and reset abort.
module tb_result_packetizer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [23:0] in_hr = '0;
    logic [9:0]  in_spo2 = '0;
    logic        stream_en = 1'b0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx [9];
    int rx_got, rx_busy, rx_first, rx_stall, rx_stab;
    bit rx_tmo;

    always #5 clk = ~clk;

    result_packetizer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_hr      (in_hr),
        .in_spo2    (in_spo2),
        .stream_en  (stream_en),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        stream_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input logic [23:0] h, input logic [9:0] s);
        @(negedge clk);
        in_valid = 1'b1;
        in_hr = h;
        in_spo2 = s;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Receive one packet; cycle count n is bounded so a dead DUT cannot hang the run.
    task automatic get_pkt(input bit toggle);
        int n;
        bit stalled, ph;
        logic [7:0] held;
        rx_got = 0; rx_busy = 0; rx_first = 0;
        rx_stall = 0; rx_stab = 0;
        n = 0; stalled = 0; ph = 1'b1; held = '0;
        while (rx_got < 9 && n < 400) begin
            @(negedge clk);
            n++;
            if (busy) rx_busy++;
            if (out_valid && rx_first == 0) rx_first = n;
            if (stalled && (out_valid !== 1'b1 || out_byte !== held))
                rx_stab++;
            out_ready = toggle ? ph : 1'b1;
            ph = ~ph;
            if (out_valid && out_ready) begin
                rx[rx_got] = out_byte;
                rx_got++;
                stalled = 0;
            end else begin
                stalled = out_valid;
                held = out_byte;
                if (out_valid) rx_stall++;
            end
        end
        rx_tmo = (rx_got < 9);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: valid=%b busy=%b byte=%h exp 0 0 00",
                     out_valid, busy, out_byte);
        end
        checks++;
        if (overflow !== 1'b0 || drop_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_ovf: ovf=%b drops=%h exp 0 00",
                     overflow, drop_count);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp [9];
        exp = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00,
                8'h4B, 8'h00, 8'h62, 8'hAD};
        do_reset();
        stream_en = 1'b1;
        push(24'h00004B, 10'd98);
        get_pkt(1'b0);
        checks++;
        if (rx_tmo) begin
            errors++;
            $display("FAIL single_tmo: got %0d bytes exp 9", rx_got);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (rx[i] !== exp[i]) begin
                errors++;
                $display("FAIL single_b%0d: got %h exp %h", i, rx[i], exp[i]);
            end
        end
        checks++;
        if (rx_first !== 2) begin
            errors++;
            $display("FAIL single_lat: got %0d exp 2", rx_first);
        end
        checks++;
        if (rx_busy !== 9) begin
            errors++;
            $display("FAIL single_busy: got %0d exp 9", rx_busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_end: busy=%b valid=%b exp 0 0",
                     busy, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [9];
        exp = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00,
                8'h4B, 8'h00, 8'h62, 8'hAD};
        do_reset();
        stream_en = 1'b1;
        push(24'h00004B, 10'd98);
        get_pkt(1'b1);
        checks++;
        if (rx_tmo) begin
            errors++;
            $display("FAIL bp_tmo: got %0d bytes exp 9", rx_got);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (rx[i] !== exp[i]) begin
                errors++;
                $display("FAIL bp_b%0d: got %h exp %h", i, rx[i], exp[i]);
            end
        end
        checks++;
        if (rx_stab !== 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable stalls exp 0", rx_stab);
        end
        checks++;
        if (rx_stall < 4) begin
            errors++;
            $display("FAIL bp_stalls: got %0d stalls exp >=4", rx_stall);
        end
        push(24'h00004B, 10'd98);
        get_pkt(1'b0);
        checks++;
        if (rx[2] !== 8'h01 || rx[8] !== 8'hAE) begin
            errors++;
            $display("FAIL bp_seq1: seq=%h csum=%h exp 01 AE", rx[2], rx[8]);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 6; i++) push(24'(i), 10'd0);
        @(negedge clk);
        checks++;
        if (drop_count !== 8'd2 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_count: drops=%0d ovf=%b exp 2 1",
                     drop_count, overflow);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_hold: valid=%b exp 0", out_valid);
        end
        stream_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            get_pkt(1'b0);
            checks++;
            if (rx_tmo || rx[2] !== 8'(i - 1) || rx[5] !== 8'(i) ||
                rx[8] !== 8'(2 * i - 1)) begin
                errors++;
                $display("FAIL ovf_pkt%0d: seq=%h hr=%h csum=%h exp %h %h %h",
                         i, rx[2], rx[5], rx[8], 8'(i - 1), 8'(i), 8'(2 * i - 1));
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || drop_count !== 8'd2) begin
            errors++;
            $display("FAIL ovf_after: valid=%b drops=%0d exp 0 2",
                     out_valid, drop_count);
        end
    endtask

    task automatic test_max_values();
        logic [7:0] exp [9];
        exp = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'hFF,
                8'hFF, 8'h03, 8'hFF, 8'hFF};
        do_reset();
        stream_en = 1'b1;
        push(24'hFFFFFF, 10'h3FF);
        get_pkt(1'b0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (rx_tmo || rx[i] !== exp[i]) begin
                errors++;
                $display("FAIL max_b%0d: got %h exp %h", i, rx[i], exp[i]);
            end
        end
    endtask

    task automatic test_seq_wrap();
        int tmo_cnt;
        tmo_cnt = 0;
        do_reset();
        stream_en = 1'b1;
        for (int p = 1; p <= 257; p++) begin
            push(24'd0, 10'd0);
            get_pkt(1'b0);
            if (rx_tmo) tmo_cnt++;
            if (p == 256) begin
                checks++;
                if (rx[2] !== 8'hFF || rx[8] !== 8'hFF) begin
                    errors++;
                    $display("FAIL wrap_256: seq=%h csum=%h exp FF FF",
                             rx[2], rx[8]);
                end
            end
            if (p == 257) begin
                checks++;
                if (rx[2] !== 8'h00 || rx[8] !== 8'h00) begin
                    errors++;
                    $display("FAIL wrap_257: seq=%h csum=%h exp 00 00",
                             rx[2], rx[8]);
                end
            end
        end
        checks++;
        if (tmo_cnt !== 0) begin
            errors++;
            $display("FAIL wrap_tmo: got %0d timeouts exp 0", tmo_cnt);
        end
    endtask

    task automatic test_drop_saturation();
        do_reset();
        for (int i = 0; i < 304; i++) begin
            push(24'(i), 10'd0);
            if (i == 257) begin
                @(negedge clk);
                checks++;
                if (drop_count !== 8'd254) begin
                    errors++;
                    $display("FAIL sat_254: got %0d exp 254", drop_count);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (drop_count !== 8'd255 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_255: drops=%0d ovf=%b exp 255 1",
                     drop_count, overflow);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] exp [9];
        int got, n;
        exp = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00,
                8'h4B, 8'h00, 8'h62, 8'hAD};
        do_reset();
        for (int i = 1; i <= 5; i++) push(24'(i), 10'd0);
        stream_en = 1'b1;
        out_ready = 1'b1;
        got = 0;
        n = 0;
        while (got < 4 && n < 50) begin
            @(negedge clk);
            n++;
            if (out_valid) got++;
        end
        checks++;
        if (got !== 4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: bytes=%0d ovf=%b exp 4 1", got, overflow);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 ||
            drop_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_rst: valid=%b busy=%b ovf=%b drops=%0d exp 0 0 0 0",
                     out_valid, busy, overflow, drop_count);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_empty: valid=%b exp 0", out_valid);
        end
        push(24'h00004B, 10'd98);
        get_pkt(1'b0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (rx_tmo || rx[i] !== exp[i]) begin
                errors++;
                $display("FAIL mid_b%0d: got %h exp %h", i, rx[i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_max_values();
        test_seq_wrap();
        test_drop_saturation();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
